// File: rtl/dcmac_reset_seq.sv
// dcmac_reset_seq
//
// Multi-port DCMAC reset sequencer behind a small register map. A register
// write queues a global reset or one or more per-port RX datapath resets.
// The sequencer then runs the queued resets one at a time. Each one is a
// fixed-width GT reset pulse followed by a bounded wait for the matching
// reset-done. A completion increments SEQ_COUNT; an expired wait sets a
// sticky TIMEOUT bit.
//
// Ports
//   clk, reset              sole clock; asynchronous active-high reset
//   wr_en/wr_idx/wr_data    single-cycle register write strobe
//   wr_ack/wr_resp          registered write response (OKAY=0, DECERR=3)
//   rd_en/rd_idx            single-cycle register read strobe
//   rd_valid/rd_data/rd_resp registered read response, data zero-extended
//   gt_loopback             GT loopback mode (LOOPBACK register)
//   gt_reset_all            global GT reset pulse
//   gt_reset_rx_datapath    per-port RX datapath reset pulse
//   rx_reset_done           per-port RX reset complete (synchronous)
//   tx_reset_done           per-port TX reset complete (synchronous)
//
// Register map
//   0 LOOPBACK  RW  [LB_W-1:0]
//   1 RESET_ALL W: bit0 queues a global reset; R: {busy, all_pend}
//   2 RX_REQ    W: OR into rx_pend;            R: rx_pend
//   3 RX_DONE   RO  rx_reset_done
//   4 TX_DONE   RO  tx_reset_done
//   5 TIMEOUT   W1C sticky, bit PORTS = global reset
//   6 SEQ_COUNT RO  saturating 16-bit count of completed sequences

module dcmac_reset_seq #(
    parameter int PORTS          = 2,
    parameter int LB_W           = 3,
    parameter int PULSE_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_idx,
    input  logic [31:0]       wr_data,
    output logic              wr_ack,
    output logic [1:0]        wr_resp,
    input  logic              rd_en,
    input  logic [7:0]        rd_idx,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_resp,
    output logic [LB_W-1:0]   gt_loopback,
    output logic              gt_reset_all,
    output logic [PORTS-1:0]  gt_reset_rx_datapath,
    input  logic [PORTS-1:0]  rx_reset_done,
    input  logic [PORTS-1:0]  tx_reset_done
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [7:0] R_LOOPBACK  = 8'd0;
    localparam logic [7:0] R_RESET_ALL = 8'd1;
    localparam logic [7:0] R_RX_REQ    = 8'd2;
    localparam logic [7:0] R_RX_DONE   = 8'd3;
    localparam logic [7:0] R_TX_DONE   = 8'd4;
    localparam logic [7:0] R_TIMEOUT   = 8'd5;
    localparam logic [7:0] R_SEQ_COUNT = 8'd6;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Counters load N-1 and the phase ends on the cycle the count is zero,
    // giving exactly N cycles in PULSE and at most N cycles in WAIT.
    localparam logic [31:0] PULSE_LOAD   = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [31:0]      cnt;
    logic             tgt_all;
    logic [PW-1:0]    tgt_port;
    logic             all_pend;
    logic [PORTS-1:0] rx_pend;
    logic [PORTS:0]   timeout_q;
    logic [15:0]      seq_count;
    logic             busy;

    // Upper write-data bits have no register behind them.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Pending-port selection: lowest set bit of rx_pend
    // ------------------------------------------------------------------
    logic [PORTS-1:0] pend_onehot;
    logic [PW-1:0]    pend_idx;

    assign pend_onehot = rx_pend & (~rx_pend + 1'b1);

    always_comb begin
        pend_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (rx_pend[i]) pend_idx = PW'(i);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer decisions
    // ------------------------------------------------------------------
    logic done_now;
    logic launch_all, launch_port, pulse_end, seq_ok, seq_to;

    assign done_now = tgt_all ? ((&rx_reset_done) & (&tx_reset_done))
                              : rx_reset_done[tgt_port];

    always_comb begin
        launch_all  = 1'b0;
        launch_port = 1'b0;
        pulse_end   = 1'b0;
        seq_ok      = 1'b0;
        seq_to      = 1'b0;
        case (state)
            S_IDLE: begin
                if (all_pend)      launch_all  = 1'b1;
                else if (|rx_pend) launch_port = 1'b1;
            end
            S_PULSE: pulse_end = (cnt == '0);
            S_WAIT: begin
                // A done seen on the last WAIT cycle still counts as success.
                if (done_now)         seq_ok = 1'b1;
                else if (cnt == '0)   seq_to = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    logic             wr_lb, wr_all, wr_rx, wr_to, wr_valid_idx;
    logic [PORTS-1:0] rx_clr, rx_set;
    logic [PORTS:0]   to_clr, to_set;

    assign wr_valid_idx = (wr_idx <= R_SEQ_COUNT);
    assign wr_lb  = wr_en && (wr_idx == R_LOOPBACK);
    assign wr_all = wr_en && (wr_idx == R_RESET_ALL);
    assign wr_rx  = wr_en && (wr_idx == R_RX_REQ);
    assign wr_to  = wr_en && (wr_idx == R_TIMEOUT);

    assign rx_clr = launch_port ? pend_onehot : '0;
    assign rx_set = wr_rx ? wr_data[PORTS-1:0] : '0;
    assign to_clr = wr_to ? wr_data[PORTS:0] : '0;

    always_comb begin
        to_set = '0;
        if (seq_to) begin
            if (tgt_all) to_set[PORTS]    = 1'b1;
            else         to_set[tgt_port] = 1'b1;
        end
    end

    // Sets are ORed in after clears so a coincident set always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gt_loopback <= '0;
            all_pend    <= 1'b0;
            rx_pend     <= '0;
            timeout_q   <= '0;
            seq_count   <= '0;
        end else begin
            if (wr_lb) gt_loopback <= wr_data[LB_W-1:0];
            all_pend  <= (all_pend & ~launch_all) | (wr_all & wr_data[0]);
            rx_pend   <= (rx_pend & ~rx_clr) | rx_set;
            timeout_q <= (timeout_q & ~to_clr) | to_set;
            if (seq_ok && (seq_count != 16'hFFFF)) seq_count <= seq_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state and reset outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            tgt_all              <= 1'b0;
            tgt_port             <= '0;
            gt_reset_all         <= 1'b0;
            gt_reset_rx_datapath <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_all) begin
                        tgt_all      <= 1'b1;
                        gt_reset_all <= 1'b1;
                        cnt          <= PULSE_LOAD;
                        state        <= S_PULSE;
                    end else if (launch_port) begin
                        tgt_all              <= 1'b0;
                        tgt_port             <= pend_idx;
                        gt_reset_rx_datapath <= pend_onehot;
                        cnt                  <= PULSE_LOAD;
                        state                <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (pulse_end) begin
                        gt_reset_all         <= 1'b0;
                        gt_reset_rx_datapath <= '0;
                        cnt                  <= TIMEOUT_LOAD;
                        state                <= S_WAIT;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_WAIT: begin
                    if (seq_ok || seq_to) state <= S_IDLE;
                    else                  cnt   <= cnt - 32'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read mux and responses
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic        rd_err;

    always_comb begin
        rd_mux = '0;
        rd_err = 1'b0;
        case (rd_idx)
            R_LOOPBACK:  rd_mux = 32'(gt_loopback);
            R_RESET_ALL: rd_mux = {30'd0, busy, all_pend};
            R_RX_REQ:    rd_mux = 32'(rx_pend);
            R_RX_DONE:   rd_mux = 32'(rx_reset_done);
            R_TX_DONE:   rd_mux = 32'(tx_reset_done);
            R_TIMEOUT:   rd_mux = 32'(timeout_q);
            R_SEQ_COUNT: rd_mux = {16'd0, seq_count};
            default:     rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ack   <= 1'b0;
            wr_resp  <= RESP_OKAY;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_resp  <= RESP_OKAY;
        end else begin
            wr_ack   <= wr_en;
            wr_resp  <= (wr_en && !wr_valid_idx) ? RESP_DECERR : RESP_OKAY;
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_mux : '0;
            rd_resp  <= (rd_en && rd_err) ? RESP_DECERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_dcmac_reset_seq.sv
// Testbench for dcmac_reset_seq. A timestamp-based reference model tracks
// pending requests and the start time of the active sequence. Every clock,
// it predicts all registered outputs and read data.
module tb_dcmac_reset_seq;
    localparam int PORTS = 2;
    localparam int LB_W  = 3;
    localparam int P     = 16;
    localparam int T     = 50;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_idx = '0;
    logic [31:0]       wr_data = '0;
    logic              wr_ack;
    logic [1:0]        wr_resp;
    logic              rd_en = 1'b0;
    logic [7:0]        rd_idx = '0;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic [LB_W-1:0]   gt_loopback;
    logic              gt_reset_all;
    logic [PORTS-1:0]  gt_reset_rx_datapath;
    logic [PORTS-1:0]  rx_reset_done = '0;
    logic [PORTS-1:0]  tx_reset_done = '0;

    always #5 clk = ~clk;

    dcmac_reset_seq #(.PORTS(PORTS), .LB_W(LB_W), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack), .wr_resp(wr_resp),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .rd_resp(rd_resp),
        .gt_loopback(gt_loopback), .gt_reset_all(gt_reset_all),
        .gt_reset_rx_datapath(gt_reset_rx_datapath),
        .rx_reset_done(rx_reset_done), .tx_reset_done(tx_reset_done)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: pending requests plus the edge at which the active
    // sequence's reset rose; the phase is derived from elapsed edges.
    logic             m_all;
    logic [PORTS-1:0] m_rx;
    logic [PORTS:0]   m_to;
    int               m_seq;
    logic [LB_W-1:0]  m_lb;
    logic             m_act;
    int               m_tgt;   // PORTS means global reset
    int               m_t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_clear();
        m_all = 0; m_rx = '0; m_to = '0; m_seq = 0; m_lb = '0; m_act = 0; m_tgt = 0; m_t0 = 0;
    endtask

    function automatic logic [33:0] mread(input logic [7:0] idx,
                                          input logic [PORTS-1:0] rxd, input logic [PORTS-1:0] txd);
        case (idx)
            8'd0: return {2'd0, 32'(m_lb)};
            8'd1: return {2'd0, 30'd0, m_act, m_all};
            8'd2: return {2'd0, 32'(m_rx)};
            8'd3: return {2'd0, 32'(rxd)};
            8'd4: return {2'd0, 32'(txd)};
            8'd5: return {2'd0, 32'(m_to)};
            8'd6: return {2'd0, 32'(m_seq)};
            default: return {2'd3, 32'd0};
        endcase
    endfunction

    // One clock: capture inputs, advance the model on the edge, compare #1 later.
    task automatic tick();
        logic [33:0]      r;
        logic [PORTS-1:0] rxd, txd, clr_rx, set_rx, exp_rx;
        logic [PORTS:0]   set_to, w1c;
        logic             cwr, crd, clr_all, set_all, done, exp_all;
        logic [7:0]       cwi;
        logic [31:0]      cwd;
        int               k, el;
        rxd = rx_reset_done; txd = tx_reset_done;
        cwr = wr_en; cwi = wr_idx; cwd = wr_data; crd = rd_en;
        r = mread(rd_idx, rxd, txd);
        @(posedge clk);
        edge_n++;
        clr_all = 0; set_all = 0; clr_rx = '0; set_rx = '0; set_to = '0; w1c = '0; k = 0;
        if (!m_act) begin
            if (m_all) begin
                clr_all = 1; m_act = 1; m_tgt = PORTS; m_t0 = edge_n;
            end else if (m_rx != '0) begin
                for (int i = PORTS - 1; i >= 0; i--) if (m_rx[i]) k = i;
                clr_rx[k] = 1; m_act = 1; m_tgt = k; m_t0 = edge_n;
            end
        end else begin
            el = edge_n - m_t0;
            if (el > P) begin
                done = (m_tgt == PORTS) ? ((&rxd) && (&txd)) : rxd[m_tgt];
                if (done) begin
                    if (m_seq < 65535) m_seq++;
                    m_act = 0;
                end else if (el - P == T) begin
                    set_to[m_tgt] = 1; m_act = 0;
                end
            end
        end
        if (cwr) begin
            case (cwi)
                8'd0: m_lb = cwd[LB_W-1:0];
                8'd1: set_all = cwd[0];
                8'd2: set_rx = cwd[PORTS-1:0];
                8'd5: w1c = cwd[PORTS:0];
                default: ;
            endcase
        end
        m_all = (m_all & ~clr_all) | set_all;
        m_rx  = (m_rx & ~clr_rx) | set_rx;
        m_to  = (m_to & ~w1c) | set_to;
        exp_all = 0; exp_rx = '0;
        if (m_act && (edge_n - m_t0) < P) begin
            if (m_tgt == PORTS) exp_all = 1;
            else exp_rx[m_tgt] = 1;
        end
        #1;
        chk("wr_ack", 32'(wr_ack), 32'(cwr));
        if (cwr) chk("wr_resp", 32'(wr_resp), (cwi <= 8'd6) ? 32'd0 : 32'd3);
        chk("rd_valid", 32'(rd_valid), 32'(crd));
        if (crd) begin
            chk("rd_data", rd_data, r[31:0]);
            chk("rd_resp", 32'(rd_resp), 32'(r[33:32]));
        end
        chk("gt_loopback", 32'(gt_loopback), 32'(m_lb));
        chk("gt_reset_all", 32'(gt_reset_all), 32'(exp_all));
        chk("gt_reset_rx", 32'(gt_reset_rx_datapath), 32'(exp_rx));
    endtask

    task automatic wr(input logic [7:0] idx, input logic [31:0] d, output logic [1:0] resp);
        wr_en = 1; wr_idx = idx; wr_data = d;
        tick();
        resp = wr_resp;
        wr_en = 0;
    endtask

    task automatic rd(input logic [7:0] idx, output logic [31:0] d, output logic [1:0] resp);
        rd_en = 1; rd_idx = idx;
        tick();
        d = rd_data; resp = rd_resp;
        rd_en = 0;
    endtask

    // Tick until any reset output equals want (bounded).
    task automatic wait_out(input logic want);
        int n;
        n = 0;
        while (((gt_reset_all | (|gt_reset_rx_datapath)) != want) && n < 300) begin
            tick(); n++;
        end
        if (n >= 300) chk("wait_bound", 32'(n), 32'd0);
    endtask

    task automatic do_reset();
        wr_en = 0; rd_en = 0;
        reset = 1; #1;
        chk("rst_gt_all", 32'(gt_reset_all), 32'd0);
        chk("rst_gt_rx", 32'(gt_reset_rx_datapath), 32'd0);
        chk("rst_loopback", 32'(gt_loopback), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  idx;
        logic [31:0] data;
        logic [31:0] exp;    // read data, or loopback value after a LOOPBACK write
        logic [1:0]  resp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] d;
    logic [1:0]  rs;
    int          w, zeros, first0, first1;
    bit          got;

    initial begin
        model_clear();
        #1;
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        do_reset();

        // ---- register map table ----
        for (int i = 0; i <= 6; i++) tbl.push_back('{1'b0, 8'(i), 32'd0, 32'd0, 2'd0});
        tbl.push_back('{1'b0, 8'd7,   32'd0, 32'd0, 2'd3});
        tbl.push_back('{1'b0, 8'd200, 32'd0, 32'd0, 2'd3});
        tbl.push_back('{1'b1, 8'd9,   32'd5, 32'd0, 2'd3});
        tbl.push_back('{1'b1, 8'd0,   32'd5, 32'd5, 2'd0});
        tbl.push_back('{1'b0, 8'd0,   32'd0, 32'd5, 2'd0});
        tbl.push_back('{1'b1, 8'd0,   32'hFFFF_FFFA, 32'd2, 2'd0});
        tbl.push_back('{1'b1, 8'd200, 32'd7, 32'd0, 2'd3});
        tbl.push_back('{1'b0, 8'd0,   32'd0, 32'd2, 2'd0});
        tbl.push_back('{1'b1, 8'd5,   32'd7, 32'd0, 2'd0});
        tbl.push_back('{1'b0, 8'd5,   32'd0, 32'd0, 2'd0});
        tbl.push_back('{1'b1, 8'd2,   32'hFFFF_FFFC, 32'd0, 2'd0});
        tbl.push_back('{1'b0, 8'd2,   32'd0, 32'd0, 2'd0});
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                wr(tbl[i].idx, tbl[i].data, rs);
                chk("tbl_wr_resp", 32'(rs), 32'(tbl[i].resp));
                if (tbl[i].idx == 8'd0) chk("tbl_loopback", 32'(gt_loopback), tbl[i].exp);
            end else begin
                rd(tbl[i].idx, d, rs);
                chk("tbl_rd_data", d, tbl[i].exp);
                chk("tbl_rd_resp", 32'(rs), 32'(tbl[i].resp));
            end
        end

        // ---- single port ----
        do_reset();
        wr(8'd2, 32'h2, rs);
        chk("rx_pulse_early", 32'(gt_reset_rx_datapath), 32'd0);
        tick();
        chk("rx_pulse_start", 32'(gt_reset_rx_datapath), 32'h2);
        w = 0;
        for (int i = 0; i < 40 && gt_reset_rx_datapath == 2'b10; i++) begin w++; tick(); end
        chk("rx_pulse_width", 32'(w), 32'(P));
        repeat (10) tick();
        rx_reset_done = 2'b10;
        tick(); tick();
        rx_reset_done = 2'b00;
        rd(8'd1, d, rs); chk("single_busy", d, 32'd0);
        rd(8'd6, d, rs); chk("single_seq", d, 32'd1);
        rd(8'd5, d, rs); chk("single_timeout", d, 32'd0);

        // ---- queued ports ----
        do_reset();
        rx_reset_done = 2'b11;
        wr(8'd2, 32'h3, rs);
        first0 = -1; first1 = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gt_reset_rx_datapath[0] && first0 < 0) first0 = edge_n;
            if (gt_reset_rx_datapath[1] && first1 < 0) first1 = edge_n;
        end
        chk("queued_port0_seen", 32'(first0 >= 0), 32'd1);
        chk("queued_gap", 32'(first1 - first0), 32'(P + 2));
        rd(8'd6, d, rs); chk("queued_seq", d, 32'd2);
        rx_reset_done = 2'b00;

        // ---- timeout ----
        do_reset();
        wr(8'd2, 32'h1, rs);
        wait_out(1'b1); wait_out(1'b0);
        zeros = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            rd(8'd5, d, rs);
            if (d[0]) got = 1; else zeros++;
        end
        chk("timeout_set", 32'(got), 32'd1);
        chk("timeout_latency", 32'(zeros), 32'(T));
        rd(8'd6, d, rs); chk("timeout_seq", d, 32'd0);
        wr(8'd5, 32'h1, rs);
        rd(8'd5, d, rs); chk("timeout_w1c", d, 32'd0);
        // W1C on the same edge as the timeout set: set wins
        wr(8'd2, 32'h1, rs);
        wait_out(1'b1); wait_out(1'b0);
        repeat (T - 1) tick();
        wr(8'd5, 32'h1, rs);
        rd(8'd5, d, rs); chk("timeout_set_wins", d, 32'd1);
        // request write on the launch edge that clears the same bit: set wins
        wr(8'd2, 32'h1, rs);
        wr(8'd2, 32'h1, rs);
        rd(8'd2, d, rs); chk("pend_set_wins", d, 32'd1);

        // ---- priority and global done ----
        do_reset();
        wr(8'd2, 32'h1, rs);
        wait_out(1'b1); wait_out(1'b0);
        wr(8'd2, 32'h2, rs);
        wr(8'd1, 32'h1, rs);
        wait_out(1'b1);
        chk("prio_all_first", 32'(gt_reset_all), 32'd1);
        chk("prio_rx_idle", 32'(gt_reset_rx_datapath), 32'd0);
        wait_out(1'b0);
        rx_reset_done = 2'b11; tx_reset_done = 2'b01;
        repeat (5) tick();
        rd(8'd1, d, rs); chk("all_waits_tx", d, 32'd2);
        tx_reset_done = 2'b11;
        tick(); tick();
        wait_out(1'b1);
        chk("prio_port1_next", 32'(gt_reset_rx_datapath), 32'h2);
        wait_out(1'b0);
        tick(); tick();
        rd(8'd6, d, rs); chk("prio_seq", d, 32'd2);
        rd(8'd5, d, rs); chk("prio_timeout", d, 32'd1);

        // ---- async reset mid-pulse ----
        rx_reset_done = '0; tx_reset_done = '0;
        wr(8'd2, 32'h1, rs);
        wait_out(1'b1);
        chk("midrst_pulse", 32'(gt_reset_rx_datapath), 32'h1);
        wr(8'd2, 32'h2, rs);
        tick();
        #2 reset = 1;
        #1;
        chk("midrst_async_drop", 32'(gt_reset_rx_datapath), 32'd0);
        chk("midrst_all", 32'(gt_reset_all), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rd(8'd2, d, rs); chk("midrst_pend", d, 32'd0);
        rd(8'd6, d, rs); chk("midrst_seq", d, 32'd0);
        rd(8'd5, d, rs); chk("midrst_timeout", d, 32'd0);
        rd(8'd1, d, rs); chk("midrst_busy", d, 32'd0);
        repeat (5) tick();

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wr_en = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: wr_idx = 8'd0;
                1: wr_idx = 8'd1;
                2: wr_idx = 8'd2;
                3: wr_idx = 8'd5;
                default: wr_idx = 8'd7;
            endcase
            wr_data = $urandom;
            rd_en = ($urandom_range(0, 3) == 0);
            rd_idx = 8'($urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) rx_reset_done = PORTS'($urandom);
            if ($urandom_range(0, 15) == 0) tx_reset_done = PORTS'($urandom);
            tick();
        end
        wr_en = 0;
        for (int i = 0; i <= 7; i++) rd(8'(i), d, rs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
